// File: rtl/ofdm_sync_pkg.sv
// Shared frequency-sync types: phase/angle widths, CORDIC request tags and
// the quadrant extension that turns a CORDIC result into a 34-bit phase.
package ofdm_sync_pkg;
  localparam int PHASE_W = 34;
  localparam int ANGLE_W = 32;

  localparam logic TAG_A = 1'b0;
  localparam logic TAG_B = 1'b1;

  function automatic logic [PHASE_W-1:0] quad_ext(input logic [1:0]         quart,
                                                  input logic [ANGLE_W-1:0] angle);
    return {quart[1], quart[1] ^ quart[0], angle};
  endfunction
endpackage

// File: rtl/ofdm_tag_fifo.sv
// Single-bit tag FIFO tracking in-flight CORDIC operations; zero-latency head read.
// Backpressure: push ignored when full, pop ignored when empty; callers gate on full/empty.
module ofdm_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     push,
  input  logic                     push_dat,
  input  logic                     pop,
  output logic                     pop_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/ofdm_atan_scheduler.sv
// Shares one CORDIC between preamble A/B phase requests; 1 cycle request->issue, return->strobe, strobe->pair.
// Backpressure: issue stalls at MAX_INFLIGHT outstanding; a repeated request before issue overwrites (o_ovr).
module ofdm_atan_scheduler
  import ofdm_sync_pkg::*;
#(
  parameter int DATA_SIZE    = 16,
  parameter int MAX_INFLIGHT = 4,
  parameter int INC_SHIFT    = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_req_a,
  input  logic [DATA_SIZE+7:0]   i_req_a_i,
  input  logic [DATA_SIZE+7:0]   i_req_a_q,
  input  logic                   i_req_b,
  input  logic [DATA_SIZE+7:0]   i_req_b_i,
  input  logic [DATA_SIZE+7:0]   i_req_b_q,
  output logic                   o_cordic_val,
  output logic [DATA_SIZE+7:0]   o_cordic_re,
  output logic [DATA_SIZE+7:0]   o_cordic_im,
  input  logic                   i_cordic_val,
  input  logic [1:0]             i_cordic_quart,
  input  logic [ANGLE_W-1:0]     i_cordic_angle,
  output logic                   o_phase_a_valid,
  output logic                   o_phase_b_valid,
  output logic [PHASE_W-1:0]     o_phase_a,
  output logic [PHASE_W-1:0]     o_phase_b,
  output logic                   o_pair_valid,
  output logic [PHASE_W-1:0]     o_begin_phase,
  output logic [PHASE_W-1:0]     o_add_phase,
  output logic                   o_busy,
  output logic                   o_ovr,
  output logic                   o_err
);
  localparam int CW = DATA_SIZE + 8;

  logic                         pending_a, pending_b;
  logic [CW-1:0]                pend_a_i, pend_a_q, pend_b_i, pend_b_q;
  logic                         fresh_a, fresh_b;
  logic                         rr_ptr;
  logic                         issue_a, issue_b, issue;
  logic                         push_tag, head_tag, ret_pop;
  logic [$clog2(MAX_INFLIGHT):0] tag_count;
  logic                         tag_empty, tag_full;
  logic [PHASE_W-1:0]           ret_phase, shr_a, shr_b, add_next;
  logic                         pair_go;

  ofdm_tag_fifo #(.DEPTH(MAX_INFLIGHT)) u_tag_fifo (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .push     (issue),
    .push_dat (push_tag),
    .pop      (ret_pop),
    .pop_dat  (head_tag),
    .count    (tag_count),
    .empty    (tag_empty),
    .full     (tag_full)
  );

  // Round-robin only matters when both sources are waiting.
  always_comb begin
    issue_a = 1'b0;
    issue_b = 1'b0;
    if (!tag_full) begin
      if (pending_a && (!pending_b || rr_ptr == TAG_A)) issue_a = 1'b1;
      else if (pending_b)                                issue_b = 1'b1;
    end
  end

  assign issue     = issue_a | issue_b;
  assign push_tag  = issue_b ? TAG_B : TAG_A;
  assign ret_pop   = i_cordic_val && !tag_empty;
  assign ret_phase = quad_ext(i_cordic_quart, i_cordic_angle);
  assign pair_go   = fresh_a & fresh_b;
  assign shr_a     = o_phase_a >> INC_SHIFT;
  assign shr_b     = o_phase_b >> INC_SHIFT;
  assign add_next  = -(shr_b - shr_a);
  assign o_busy    = pending_a | pending_b | (tag_count != '0);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      pending_a       <= 1'b0;
      pending_b       <= 1'b0;
      pend_a_i        <= '0;
      pend_a_q        <= '0;
      pend_b_i        <= '0;
      pend_b_q        <= '0;
      fresh_a         <= 1'b0;
      fresh_b         <= 1'b0;
      rr_ptr          <= TAG_A;
      o_cordic_val    <= 1'b0;
      o_cordic_re     <= '0;
      o_cordic_im     <= '0;
      o_phase_a_valid <= 1'b0;
      o_phase_b_valid <= 1'b0;
      o_phase_a       <= '0;
      o_phase_b       <= '0;
      o_pair_valid    <= 1'b0;
      o_begin_phase   <= '0;
      o_add_phase     <= '0;
      o_ovr           <= 1'b0;
      o_err           <= 1'b0;
    end else begin
      if (i_req_a) begin
        pend_a_i  <= i_req_a_i;
        pend_a_q  <= i_req_a_q;
        pending_a <= 1'b1;
        if (pending_a && !issue_a) o_ovr <= 1'b1;
      end else if (issue_a) begin
        pending_a <= 1'b0;
      end

      if (i_req_b) begin
        pend_b_i  <= i_req_b_i;
        pend_b_q  <= i_req_b_q;
        pending_b <= 1'b1;
        if (pending_b && !issue_b) o_ovr <= 1'b1;
      end else if (issue_b) begin
        pending_b <= 1'b0;
      end

      o_cordic_val <= issue;
      if (issue) begin
        o_cordic_re <= issue_a ? pend_a_i : pend_b_i;
        o_cordic_im <= issue_a ? pend_a_q : pend_b_q;
        rr_ptr      <= ~push_tag;
      end

      if (i_cordic_val && tag_empty) o_err <= 1'b1;

      o_phase_a_valid <= ret_pop && (head_tag == TAG_A);
      o_phase_b_valid <= ret_pop && (head_tag == TAG_B);
      if (ret_pop && head_tag == TAG_A) o_phase_a <= ret_phase;
      if (ret_pop && head_tag == TAG_B) o_phase_b <= ret_phase;

      // A result landing in the pairing cycle keeps its fresh flag set.
      if (ret_pop && head_tag == TAG_A) fresh_a <= 1'b1;
      else if (pair_go)                 fresh_a <= 1'b0;
      if (ret_pop && head_tag == TAG_B) fresh_b <= 1'b1;
      else if (pair_go)                 fresh_b <= 1'b0;

      o_pair_valid <= pair_go;
      if (pair_go) begin
        o_begin_phase <= -o_phase_b;
        o_add_phase   <= add_next;
      end
    end
  end
endmodule

// File: tb/tb_ofdm_atan_scheduler.sv
// Directed bench for ofdm_atan_scheduler with a behavioural fixed-latency CORDIC.
// The model derives quart/angle from operand bits so every expected phase is hand-computable.
module tb_ofdm_atan_scheduler;
  localparam int CW = 24;

  logic          i_clk;
  logic          i_reset_n;
  logic          i_req_a, i_req_b;
  logic [CW-1:0] i_req_a_i, i_req_a_q, i_req_b_i, i_req_b_q;
  logic          o_cordic_val;
  logic [CW-1:0] o_cordic_re, o_cordic_im;
  logic          i_cordic_val;
  logic [1:0]    i_cordic_quart;
  logic [31:0]   i_cordic_angle;
  logic          o_phase_a_valid, o_phase_b_valid;
  logic [33:0]   o_phase_a, o_phase_b;
  logic          o_pair_valid;
  logic [33:0]   o_begin_phase, o_add_phase;
  logic          o_busy, o_ovr, o_err;

  ofdm_atan_scheduler #(.DATA_SIZE(16), .MAX_INFLIGHT(4), .INC_SHIFT(8)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_req_a(i_req_a), .i_req_a_i(i_req_a_i), .i_req_a_q(i_req_a_q),
    .i_req_b(i_req_b), .i_req_b_i(i_req_b_i), .i_req_b_q(i_req_b_q),
    .o_cordic_val(o_cordic_val), .o_cordic_re(o_cordic_re), .o_cordic_im(o_cordic_im),
    .i_cordic_val(i_cordic_val), .i_cordic_quart(i_cordic_quart), .i_cordic_angle(i_cordic_angle),
    .o_phase_a_valid(o_phase_a_valid), .o_phase_b_valid(o_phase_b_valid),
    .o_phase_a(o_phase_a), .o_phase_b(o_phase_b),
    .o_pair_valid(o_pair_valid), .o_begin_phase(o_begin_phase), .o_add_phase(o_add_phase),
    .o_busy(o_busy), .o_ovr(o_ovr), .o_err(o_err)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct { int due; logic [1:0] q; logic [31:0] a; } rsp_t;
  rsp_t          rq[$];
  logic [CW-1:0] iss_re[$];
  int            vec = 0, bad = 0;
  int            cyc = 0, lat = 20;
  int            a_cnt = 0, b_cnt = 0, pair_cnt = 0;
  int            a_cyc = 0, b_cyc = 0, pair_cyc = 0;
  logic [33:0]   a_last = '0, b_last = '0, pair_begin = '0, pair_add = '0;
  int            inj_seq = 0, inj_done = 0;
  logic [1:0]    inj_q = '0;
  logic [31:0]   inj_a = '0;

  // CORDIC model and output monitor: quart = re[17:16], angle = {re[15:0], im[15:0]}, re[20] = source.
  initial begin
    i_cordic_val   = 1'b0;
    i_cordic_quart = '0;
    i_cordic_angle = '0;
    forever begin
      @(posedge i_clk);
      #1;
      cyc++;
      if (o_cordic_val) begin
        iss_re.push_back(o_cordic_re);
        rq.push_back('{due: cyc + lat - 1, q: o_cordic_re[17:16], a: {o_cordic_re[15:0], o_cordic_im[15:0]}});
      end
      if (o_phase_a_valid) begin a_cnt++; a_last = o_phase_a; a_cyc = cyc; end
      if (o_phase_b_valid) begin b_cnt++; b_last = o_phase_b; b_cyc = cyc; end
      if (o_pair_valid) begin pair_cnt++; pair_begin = o_begin_phase; pair_add = o_add_phase; pair_cyc = cyc; end
      i_cordic_val = 1'b0;
      if (rq.size() != 0 && rq[0].due <= cyc) begin
        i_cordic_val   = 1'b1;
        i_cordic_quart = rq[0].q;
        i_cordic_angle = rq[0].a;
        void'(rq.pop_front());
      end else if (inj_seq != inj_done) begin
        i_cordic_val   = 1'b1;
        i_cordic_quart = inj_q;
        i_cordic_angle = inj_a;
        inj_done++;
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic noreq();
    i_req_a = 1'b0;
    i_req_b = 1'b0;
  endtask

  task automatic req(input logic src, input logic [CW-1:0] re, input logic [CW-1:0] im);
    if (src) begin i_req_b = 1'b1; i_req_b_i = re; i_req_b_q = im; end
    else     begin i_req_a = 1'b1; i_req_a_i = re; i_req_a_q = im; end
  endtask

  task automatic do_reset();
    noreq();
    i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1;
  endtask

  task automatic wait_idle(input string name, output int mx);
    bit done = 0;
    mx = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      if (rq.size() > mx) mx = rq.size();
      if (rq.size() == 0 && !o_busy) done = 1;
    end
    repeat (3) tick();
    vec++;
    if (!done) begin bad++; $display("FAIL %s_idle_timeout: still busy=%b queued=%0d, want idle", name, o_busy, rq.size()); end
  endtask

  task automatic wait_pair(input string name, input int base);
    for (int i = 0; i < 200 && pair_cnt == base; i++) tick();
    vec++;
    if (pair_cnt == base) begin bad++; $display("FAIL %s_pair_timeout: pair count %0d, want > %0d", name, pair_cnt, base); end
  endtask

  task automatic test_reset();
    do_reset();
    vec++; if (o_cordic_val !== 1'b0) begin bad++; $display("FAIL reset_cordic_val: got %b want 0", o_cordic_val); end
    vec++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    vec++; if ({o_ovr, o_err, o_pair_valid} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {o_ovr, o_err, o_pair_valid}); end
    vec++; if ({o_begin_phase, o_add_phase, o_phase_a, o_phase_b} !== '0) begin bad++; $display("FAIL reset_phases: got nonzero, want 0"); end
  endtask

  task automatic test_single_ab();
    int pb = pair_cnt, ab = a_cnt, mx;
    do_reset();
    lat = 20;
    req(0, 24'h001000, 24'h000000);
    tick();
    noreq();
    req(1, 24'h112000, 24'h000000);
    vec++; if (o_busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", o_busy); end
    tick();
    noreq();
    vec++; if ({o_cordic_val, o_cordic_re} !== {1'b1, 24'h001000}) begin bad++; $display("FAIL single_issue_a: got %b/%h want 1/001000", o_cordic_val, o_cordic_re); end
    tick();
    vec++; if ({o_cordic_val, o_cordic_re} !== {1'b1, 24'h112000}) begin bad++; $display("FAIL single_issue_b: got %b/%h want 1/112000", o_cordic_val, o_cordic_re); end
    wait_pair("single", pb);
    vec++; if (a_last !== 34'h010000000) begin bad++; $display("FAIL single_phase_a: got %h want 010000000", a_last); end
    vec++; if (b_last !== 34'h120000000) begin bad++; $display("FAIL single_phase_b: got %h want 120000000", b_last); end
    vec++; if (pair_cyc - b_cyc !== 1) begin bad++; $display("FAIL single_pair_latency: got %0d want 1", pair_cyc - b_cyc); end
    vec++; if (pair_begin !== 34'h2E0000000) begin bad++; $display("FAIL single_begin: got %h want 2E0000000", pair_begin); end
    vec++; if (pair_add !== 34'h3FEF00000) begin bad++; $display("FAIL single_add: got %h want 3FEF00000", pair_add); end
    wait_idle("single", mx);
    vec++; if (a_cnt - ab !== 1) begin bad++; $display("FAIL single_a_count: got %0d want 1", a_cnt - ab); end
    vec++; if ({o_ovr, o_err} !== 2'b00) begin bad++; $display("FAIL single_sticky: got %b want 00", {o_ovr, o_err}); end
  endtask

  task automatic test_simultaneous();
    int pb = pair_cnt, mx;
    do_reset();
    lat = 20;
    req(0, 24'h005000, 24'h000001);
    req(1, 24'h130006, 24'h000007);
    tick();
    noreq();
    tick();
    vec++; if ({o_cordic_val, o_cordic_re} !== {1'b1, 24'h005000}) begin bad++; $display("FAIL simul_first_a: got %b/%h want 1/005000", o_cordic_val, o_cordic_re); end
    tick();
    vec++; if ({o_cordic_val, o_cordic_re} !== {1'b1, 24'h130006}) begin bad++; $display("FAIL simul_then_b: got %b/%h want 1/130006", o_cordic_val, o_cordic_re); end
    wait_pair("simul", pb);
    vec++; if (a_last !== 34'h050000001) begin bad++; $display("FAIL simul_phase_a: got %h want 050000001", a_last); end
    vec++; if (b_last !== 34'h200060007) begin bad++; $display("FAIL simul_phase_b: got %h want 200060007", b_last); end
    vec++; if (b_cyc - a_cyc !== 1) begin bad++; $display("FAIL simul_return_order: got %0d want 1", b_cyc - a_cyc); end
    req(0, 24'h000777, 24'h000000);
    req(1, 24'h100888, 24'h000000);
    tick();
    noreq();
    tick();
    vec++; if ({o_cordic_val, o_cordic_re} !== {1'b1, 24'h000777}) begin bad++; $display("FAIL simul_ptr_back_to_a: got %b/%h want 1/000777", o_cordic_val, o_cordic_re); end
    wait_idle("simul", mx);
  endtask

  task automatic test_inflight();
    logic          srcs[7] = '{0, 1, 0, 1, 0, 1, 0};
    logic [CW-1:0] res[7]  = '{24'h000011, 24'h100021, 24'h000012, 24'h100022, 24'h000013, 24'h100023, 24'h000014};
    int ib, ab, mx, mx2;
    do_reset();
    lat = 30;
    ib = iss_re.size();
    ab = a_cnt;
    mx = 0;
    for (int i = 0; i < 7; i++) begin
      noreq();
      req(srcs[i], res[i], 24'h000000);
      tick();
      if (rq.size() > mx) mx = rq.size();
    end
    noreq();
    wait_idle("inflight", mx2);
    if (mx2 > mx) mx = mx2;
    vec++; if (mx !== 4) begin bad++; $display("FAIL inflight_max_outstanding: got %0d want 4", mx); end
    vec++; if (iss_re.size() - ib !== 6) begin bad++; $display("FAIL inflight_issue_count: got %0d want 6", iss_re.size() - ib); end
    if (iss_re.size() - ib >= 6) begin
      vec++; if (iss_re[ib+4] !== 24'h000014) begin bad++; $display("FAIL inflight_fifth_issue: got %h want 000014", iss_re[ib+4]); end
      vec++; if (iss_re[ib+5] !== 24'h100023) begin bad++; $display("FAIL inflight_sixth_issue: got %h want 100023", iss_re[ib+5]); end
    end
    vec++; if (a_cnt - ab !== 3) begin bad++; $display("FAIL inflight_a_results: got %0d want 3", a_cnt - ab); end
    vec++; if (a_last !== 34'h000140000) begin bad++; $display("FAIL inflight_last_a: got %h want 000140000", a_last); end
    vec++; if (o_ovr !== 1'b1) begin bad++; $display("FAIL inflight_ovr: got %b want 1", o_ovr); end
    vec++; if (o_err !== 1'b0) begin bad++; $display("FAIL inflight_err: got %b want 0", o_err); end
  endtask

  task automatic test_spurious_return();
    int ab, bb;
    do_reset();
    ab = a_cnt;
    bb = b_cnt;
    inj_q = 2'b11;
    inj_a = 32'hDEADBEEF;
    inj_seq++;
    repeat (4) tick();
    vec++; if (o_err !== 1'b1) begin bad++; $display("FAIL spurious_err: got %b want 1", o_err); end
    vec++; if ((a_cnt - ab) + (b_cnt - bb) !== 0) begin bad++; $display("FAIL spurious_strobes: got %0d want 0", (a_cnt - ab) + (b_cnt - bb)); end
    vec++; if (o_busy !== 1'b0) begin bad++; $display("FAIL spurious_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_reset_midflight();
    int ab, bb, mx;
    do_reset();
    lat = 20;
    req(0, 24'h001000, 24'h000000);
    req(1, 24'h112000, 24'h000000);
    tick();
    noreq();
    tick();
    tick();
    ab = a_cnt;
    bb = b_cnt;
    do_reset();
    vec++; if ({o_cordic_val, o_busy, o_err, o_ovr} !== 4'b0000) begin bad++; $display("FAIL midrst_outputs: got %b want 0000", {o_cordic_val, o_busy, o_err, o_ovr}); end
    wait_idle("midrst", mx);
    vec++; if (o_err !== 1'b1) begin bad++; $display("FAIL midrst_late_err: got %b want 1", o_err); end
    vec++; if ((a_cnt - ab) + (b_cnt - bb) !== 0) begin bad++; $display("FAIL midrst_strobes: got %0d want 0", (a_cnt - ab) + (b_cnt - bb)); end
  endtask

  task automatic test_back_to_back_a();
    int pb = pair_cnt, ab = a_cnt, mx;
    do_reset();
    lat = 20;
    req(0, 24'h000100, 24'h000000);
    tick();
    noreq();
    req(0, 24'h023000, 24'h000000);
    tick();
    noreq();
    repeat (5) tick();
    req(1, 24'h134000, 24'h000000);
    tick();
    noreq();
    wait_pair("dbl_a", pb);
    wait_idle("dbl_a", mx);
    vec++; if (pair_cnt - pb !== 1) begin bad++; $display("FAIL dbl_a_pair_count: got %0d want 1", pair_cnt - pb); end
    vec++; if (a_cnt - ab !== 2) begin bad++; $display("FAIL dbl_a_a_results: got %0d want 2", a_cnt - ab); end
    vec++; if (pair_begin !== 34'h1C0000000) begin bad++; $display("FAIL dbl_a_begin: got %h want 1C0000000", pair_begin); end
    vec++; if (pair_add !== 34'h000F00000) begin bad++; $display("FAIL dbl_a_add: got %h want 000F00000", pair_add); end
    vec++; if (o_ovr !== 1'b0) begin bad++; $display("FAIL dbl_a_ovr: got %b want 0", o_ovr); end
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_req_a   = 1'b0;
    i_req_b   = 1'b0;
    i_req_a_i = '0;
    i_req_a_q = '0;
    i_req_b_i = '0;
    i_req_b_q = '0;
    tick();
    test_reset();
    test_single_ab();
    test_simultaneous();
    test_inflight();
    test_spurious_return();
    test_reset_midflight();
    test_back_to_back_a();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
